proc_control_unit: RTL

- Sequencing control FSM for the simple processor datapath.
- Captures a 9-bit instruction IIIXXXYYY from the DIN bus into an internal IR.
- Steps through time-steps T0..T3 and drives every datapath enable: register in/out selects, A/G latches, bus muxing, add/sub and Done.
- Produces the XXX/YYY register codes and decode-enable that the 3-to-8 register decoders consume, and emits the resulting one-hot Rin/Rout vectors.

---
 rtl/proc_control_unit_if.sv | 34 +++
 rtl/proc_control_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/proc_control_unit_if.sv
// Control-unit bus bundle for the simple processor datapath.
//   Run, DIN     : start request and instruction/immediate bus into the control unit
//   IR, Tstep    : instruction register and current time-step (visibility)
//   Rin, Rout    : one-hot register write / bus-drive selects, bit 0 = R0
//   Ain, Gin     : A and G register loads
//   Gout, DINout : G or DIN drives the shared bus
//   AddSub, Done : ALU op (0 add, 1 sub) and last step of the instruction
// master = control unit side, slave = datapath / stimulus side.
interface proc_control_unit_if #(
    parameter int BUS_W = 9
);
    logic             Run;
    logic [BUS_W-1:0] DIN;
    logic [8:0]       IR;
    logic [1:0]       Tstep;
    logic [0:7]       Rin;
    logic [0:7]       Rout;
    logic             Ain;
    logic             Gin;
    logic             Gout;
    logic             DINout;
    logic             AddSub;
    logic             Done;

    modport master (
        input  Run, DIN,
        output IR, Tstep, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done
    );

    modport slave (
        output Run, DIN,
        input  IR, Tstep, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done
    );
endinterface

// File: rtl/proc_control_unit.sv
// Sequencing FSM for the simple processor datapath.
// Fetches a 9-bit instruction IIIXXXYYY from DIN in T0 and walks T1..T3,
// driving every datapath enable combinationally from (Tstep, IR).
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset (Tstep=0, IR=0)
//   ctl    : master side of proc_control_unit_if (Run/DIN in, controls out)
// Opcodes: 000 mv Rx,Ry | 001 mvi Rx,#D | 010 add Rx,Ry | 011 sub Rx,Ry | 1xx undefined.
module proc_control_unit #(
    parameter int BUS_W = 9
) (
    input logic                  Clock,
    input logic                  Resetn,
    proc_control_unit_if.master  ctl
);

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    tstep_e           state, state_nxt;
    logic [8:0]       ir, ir_nxt;
    logic [BUS_W-1:0] din;

    logic [2:0] op, x_code, y_code;
    logic       is_arith;

    // Register-decoder feeds: Rin always targets X; Rout picks X or Y.
    logic       rin_en, rout_en;
    logic [2:0] rout_code;

    logic ain, gin, gout, dinout, addsub, done;

    assign din      = ctl.DIN;
    assign op       = ir[8:6];
    assign x_code   = ir[5:3];
    assign y_code   = ir[2:0];
    assign is_arith = (op == OP_ADD) || (op == OP_SUB);

    // 3-to-8 decode onto a [0:7] vector so code 000 lands on R0 (leftmost).
    function automatic logic [0:7] dec3to8(input logic en, input logic [2:0] code);
        logic [0:7] d;
        d = '0;
        if (en) d[code] = 1'b1;
        return d;
    endfunction

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            ir    <= ir_nxt;
        end
    end

    always_comb begin
        // Any combination not handled below is unreachable: no enables, back to T0.
        state_nxt = T0;
        ir_nxt    = ir;
        rin_en    = 1'b0;
        rout_en   = 1'b0;
        rout_code = x_code;
        ain       = 1'b0;
        gin       = 1'b0;
        gout      = 1'b0;
        dinout    = 1'b0;
        addsub    = 1'b0;
        done      = 1'b0;

        case (state)
            T0: begin
                // Run is only looked at here; later steps never abort.
                if (ctl.Run) begin
                    ir_nxt    = din[8:0];
                    state_nxt = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        rout_en   = 1'b1;
                        rout_code = y_code;
                        rin_en    = 1'b1;
                        done      = 1'b1;
                    end
                    OP_MVI: begin
                        dinout = 1'b1;
                        rin_en = 1'b1;
                        done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_en   = 1'b1;
                        rout_code = x_code;
                        ain       = 1'b1;
                        state_nxt = T2;
                    end
                    default: begin
                        // Undefined opcode retires as a no-op.
                        done = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (is_arith) begin
                    rout_en   = 1'b1;
                    rout_code = y_code;
                    gin       = 1'b1;
                    addsub    = ir[6];
                    state_nxt = T3;
                end
            end
            T3: begin
                if (is_arith) begin
                    gout   = 1'b1;
                    rin_en = 1'b1;
                    done   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ctl.IR     = ir;
    assign ctl.Tstep  = state;
    assign ctl.Rin    = dec3to8(rin_en, x_code);
    assign ctl.Rout   = dec3to8(rout_en, rout_code);
    assign ctl.Ain    = ain;
    assign ctl.Gin    = gin;
    assign ctl.Gout   = gout;
    assign ctl.DINout = dinout;
    assign ctl.AddSub = addsub;
    assign ctl.Done   = done;

endmodule
